ln_x: RTL and testbench



---
 rtl/exp_ln_pkg.sv | 19 +
 rtl/lead_one_det16.sv | 20 ++
 rtl/mul_fast.sv | 15 +
 rtl/ln_x.sv | 166 ++++++++++++++++
 tb/tb_ln_x.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/exp_ln_pkg.sv
// Shared constants and types for the exp / ln fixed-point units (Q2.13).
package exp_ln_pkg;

  localparam logic [15:0]  LN2_Q13   = 16'd5678;
  localparam logic [15:0]  LOG2E_Q13 = 16'd11819;
  localparam int unsigned  Q_FRAC    = 13;
  localparam logic [15:0]  LN_MIN    = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ITER,
    SCALE,
    DONE
  } ln_state_t;

  typedef logic signed [15:0] q2_13_t;

endpackage

// File: rtl/lead_one_det16.sv
// Leading-one position of a 16-bit unsigned value, with an all-zero flag.
module lead_one_det16 (
  input  logic [15:0] i_val,
  output logic [3:0]  o_pos,
  output logic        o_zero
);

  // Highest set bit wins because later iterations overwrite earlier ones
  always_comb begin
    o_pos  = 4'd0;
    o_zero = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_val[i]) begin
        o_pos  = 4'(i);
        o_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mul_fast.sv
// Shared signed multiplier; full-width combinational product.
module mul_fast #(
  parameter int unsigned IN_DW = 18
) (
  input  logic signed [IN_DW-1:0]   i_a,
  input  logic signed [IN_DW-1:0]   i_b,
  output logic signed [2*IN_DW-1:0] o_p
);

  // Full-precision signed product
  always_comb begin
    o_p = (2*IN_DW)'(i_a) * (2*IN_DW)'(i_b);
  end

endmodule

// File: rtl/ln_x.sv
// Iterative Q2.13 natural log: normalise, one log2 bit per squaring, scale by ln2.
module ln_x
  import exp_ln_pkg::*;
#(
  parameter int unsigned D_W    = 16,
  parameter int unsigned FRAC_W = 13,
  parameter int unsigned MUL_W  = 18
) (
  input  logic           I_CLK,
  input  logic           I_RST_N,
  input  logic           I_VALID,
  output logic           O_READY,
  input  logic [D_W-1:0] I_X,
  output logic           O_VALID,
  input  logic           I_READY,
  output logic [D_W-1:0] O_LN,
  output logic           O_ERR
);

  localparam int unsigned P_W = 2 * MUL_W;

  ln_state_t               r_state;
  ln_state_t               w_next;
  logic [15:0]             r_x;
  logic [15:0]             r_m;
  logic signed [MUL_W-1:0] r_l;
  logic [3:0]              r_bit;
  logic                    r_err;
  logic                    r_ready;
  logic                    r_valid;
  q2_13_t                  r_ln;
  logic                    r_err_o;

  logic [3:0]              w_pos;
  logic                    w_zero;
  logic                    w_bad;
  logic signed [MUL_W-1:0] w_l0;
  logic signed [MUL_W-1:0] w_mul_a;
  logic signed [MUL_W-1:0] w_mul_b;
  logic signed [P_W-1:0]   w_prod;
  logic signed [P_W-1:0]   w_r;
  q2_13_t                  w_sat;

  lead_one_det16 u_lod (
    .i_val  (r_x),
    .o_pos  (w_pos),
    .o_zero (w_zero)
  );

  mul_fast #(.IN_DW(MUL_W)) u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  // Non-positive operands are flagged; integer part of log2 is p - 13
  always_comb begin
    w_bad = r_x[15] | w_zero;
    w_l0  = $signed({1'b0, w_pos, 13'd0}) - $signed(MUL_W'(13 << Q_FRAC));
  end

  // Multiplier squares the mantissa in ITER and applies ln2 in SCALE
  always_comb begin
    w_mul_a = $signed({2'b00, r_m});
    w_mul_b = $signed({2'b00, r_m});
    if (r_state == SCALE) begin
      w_mul_a = r_l;
      w_mul_b = $signed({2'b00, LN2_Q13});
    end
  end

  // Round half up back to Q2.13 and clamp to the 16-bit range
  always_comb begin
    w_r   = (w_prod + P_W'(4096)) >>> Q_FRAC;
    w_sat = w_r[15:0];
    if (w_r > $signed(P_W'(32767))) begin
      w_sat = 16'sh7FFF;
    end else if (w_r < -$signed(P_W'(32768))) begin
      w_sat = LN_MIN;
    end
  end

  // State register
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (I_VALID) w_next = NORM;
      NORM:    w_next = ITER;
      ITER:    if (r_bit == 4'd0) w_next = SCALE;
      SCALE:   w_next = DONE;
      DONE:    if (I_READY) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs registered from the upcoming state
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_ready <= (w_next == IDLE);
      r_valid <= (w_next == DONE);
    end
  end

  // Datapath: capture, normalise, squaring iterations, final scaling
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_x     <= '0;
      r_m     <= '0;
      r_l     <= '0;
      r_bit   <= '0;
      r_err   <= 1'b0;
      r_ln    <= '0;
      r_err_o <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (I_VALID) r_x <= I_X[15:0];
        end
        NORM: begin
          r_bit <= 4'(FRAC_W - 1);
          if (w_bad) begin
            r_err <= 1'b1;
            r_m   <= 16'h8000;
            r_l   <= '0;
          end else begin
            r_err <= 1'b0;
            r_m   <= 16'(r_x << (4'd15 - w_pos));
            r_l   <= w_l0;
          end
        end
        ITER: begin
          if (w_prod[31]) begin
            r_l <= r_l | (MUL_W'(1) << r_bit);
            r_m <= w_prod[31:16];
          end else begin
            r_m <= w_prod[30:15];
          end
          if (r_bit != 4'd0) r_bit <= r_bit - 4'd1;
        end
        SCALE: begin
          r_ln    <= r_err ? LN_MIN : w_sat;
          r_err_o <= r_err;
        end
        default: ;
      endcase
    end
  end

  assign O_READY = r_ready;
  assign O_VALID = r_valid;
  assign O_LN    = D_W'(r_ln);
  assign O_ERR   = r_err_o;

endmodule

// File: tb/tb_ln_x.sv
// Self-checking bench for ln_x against a real-valued ln reference.
module tb_ln_x;

  logic        I_CLK = 1'b0;
  logic        I_RST_N;
  logic        I_VALID;
  logic        O_READY;
  logic [15:0] I_X;
  logic        O_VALID;
  logic        I_READY;
  logic [15:0] O_LN;
  logic        O_ERR;

  int n_vec = 0;
  int n_bad = 0;

  ln_x dut (
    .I_CLK   (I_CLK),
    .I_RST_N (I_RST_N),
    .I_VALID (I_VALID),
    .O_READY (O_READY),
    .I_X     (I_X),
    .O_VALID (O_VALID),
    .I_READY (I_READY),
    .O_LN    (O_LN),
    .O_ERR   (O_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  // Single comparison point with an allowed absolute tolerance
  task automatic chk(input string tag, input int got, input int exp, input int tol);
    n_vec++;
    if ((got - exp > tol) || (exp - got > tol)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Reference: round(ln(x/8192)*8192), clamped at the bottom of Q2.13
  function automatic int ln_model(input int x);
    real v;
    int  r;
    v = $ln(real'(x) / 8192.0) * 8192.0;
    r = int'($floor(v + 0.5));
    if (r < -32768) r = -32768;
    if (r > 32767) r = 32767;
    return r;
  endfunction

  task automatic accept(input logic [15:0] x, input bit keep);
    int n;
    @(negedge I_CLK);
    I_VALID = 1'b1;
    I_X     = x;
    n = 0;
    while (!O_READY && n < 64) begin
      @(negedge I_CLK);
      n++;
    end
    if (!O_READY) chk("ready_timeout", 0, 1, 0);
    @(posedge I_CLK);
    #1;
    if (!keep) I_VALID = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge I_CLK);
      lat++;
    end while (!O_VALID && lat < 64);
    if (!O_VALID) chk("valid_timeout", 0, 1, 0);
  endtask

  task automatic finish_op(input int bp, output int ln, output int err);
    for (int i = 0; i < bp; i++) @(negedge I_CLK);
    ln  = int'($signed(O_LN));
    err = int'(O_ERR);
    I_READY = 1'b1;
    @(posedge I_CLK);
    #1;
    I_READY = 1'b0;
  endtask

  task automatic run_dir(input string tag, input logic [15:0] x,
                         input int exp_ln, input int tol, input int exp_err);
    int lat, ln, err;
    accept(x, 1'b0);
    wait_valid(lat);
    finish_op(0, ln, err);
    chk({tag, "_ln"}, ln, exp_ln, tol);
    chk({tag, "_err"}, err, exp_err, 0);
  endtask

  initial begin
    int lat, ln, err, x, bp;

    I_RST_N = 1'b0;
    I_VALID = 1'b0;
    I_READY = 1'b0;
    I_X     = '0;
    repeat (3) @(negedge I_CLK);
    chk("rst_ready", int'(O_READY), 1, 0);
    chk("rst_valid", int'(O_VALID), 0, 0);
    chk("rst_ln",    int'(O_LN),    0, 0);
    chk("rst_err",   int'(O_ERR),   0, 0);
    I_RST_N = 1'b1;

    accept(16'd8192, 1'b0);
    wait_valid(lat);
    chk("one_lat", lat, 16, 0);
    finish_op(0, ln, err);
    chk("one_ln", ln, 0, 0);
    chk("one_err", err, 0, 0);

    run_dir("two",  16'd16384, 5678,  0, 0);
    run_dir("half", 16'd4096,  -5678, 0, 0);
    run_dir("quarter", 16'd2048, -11356, 0, 0);
    run_dir("x1p5", 16'd12288, 3322,  2, 0);
    run_dir("e",    16'd22268, 8192,  2, 0);
    run_dir("small", 16'd100,  -32768, 0, 0);
    run_dir("x149", 16'd149,   -32768, 0, 0);
    run_dir("zero", 16'd0,     -32768, 0, 1);
    run_dir("neg",  16'hFF00,  -32768, 0, 1);
    run_dir("max",  16'd32767, ln_model(32767), 2, 0);

    // Long backpressure with a second request already waiting
    accept(16'd16384, 1'b1);
    I_X = 16'd4096;
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      chk("hs_ln",    int'($signed(O_LN)), 5678, 0);
      chk("hs_valid", int'(O_VALID), 1, 0);
      chk("hs_ready", int'(O_READY), 0, 0);
      @(negedge I_CLK);
    end
    I_READY = 1'b1;
    @(posedge I_CLK);
    #1;
    I_READY = 1'b0;
    @(negedge I_CLK);
    chk("hs_rel_ready", int'(O_READY), 1, 0);
    chk("hs_rel_valid", int'(O_VALID), 0, 0);
    @(posedge I_CLK);
    #1;
    I_VALID = 1'b0;
    wait_valid(lat);
    chk("hs2_lat", lat, 16, 0);
    finish_op(0, ln, err);
    chk("hs2_ln", ln, -5678, 0);

    // Reset pulse in the middle of the squaring loop
    accept(16'd12288, 1'b0);
    repeat (5) @(negedge I_CLK);
    I_RST_N = 1'b0;
    @(negedge I_CLK);
    I_RST_N = 1'b1;
    chk("mid_rst_ready", int'(O_READY), 1, 0);
    chk("mid_rst_valid", int'(O_VALID), 0, 0);
    chk("mid_rst_ln",    int'(O_LN),    0, 0);
    repeat (20) @(negedge I_CLK);
    chk("mid_rst_novalid", int'(O_VALID), 0, 0);
    run_dir("post_rst", 16'd22268, 8192, 2, 0);

    // Random sweep with random result backpressure
    for (int n = 0; n < 2000; n++) begin
      x  = int'($urandom_range(32767, 150));
      bp = int'($urandom_range(3, 0));
      accept(16'(x), 1'b0);
      wait_valid(lat);
      finish_op(bp, ln, err);
      chk($sformatf("rnd_ln x=%0d", x), ln, ln_model(x), 2);
      if (err != 0) chk($sformatf("rnd_err x=%0d", x), err, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
